cond_eval: RTL and testbench
============================

COND_EVAL -- requirements
Module: cond_eval

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-003 SHALL have port cpsr, input, 32 bits: current status register; bit31=V, bit30=C, bit29=Z, bit28=N; bits 27:0 ignored.
REQ-004 SHALL have port flag_wr_pend, input, 1 bit: an older flag-setting instruction has not yet loaded cpsr, so cpsr is stale.
REQ-005 SHALL have port in_valid, input, 1 bit: in_instr is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts in_instr this cycle; combinational.
REQ-007 SHALL have port in_instr, input, 32 bits: instruction word; condition field is in_instr[31:28].
REQ-008 SHALL have port out_valid, output, 1 bit: out_instr, out_exec and out_undef are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes the output this cycle.
REQ-010 SHALL have port out_instr, output, 32 bits: the accepted instruction, unmodified.
REQ-011 SHALL have port out_exec, output, 1 bit: the condition passed.
REQ-012 SHALL have port out_undef, output, 1 bit: the condition field was 4'b1111 (NV).
REQ-013 SHALL have port stall_cnt, output, 16 bits: count of WAIT cycles, saturating.

Function
REQ-014 SHALL implement FSM states EMPTY, WAIT and FULL.
REQ-015 SHALL define accept as in_valid && in_ready on a rising edge.
REQ-016 SHALL drive in_ready = 1 in EMPTY, 0 in WAIT, and out_ready in FULL.
REQ-017 SHALL drive out_valid = 1 only in FULL.
REQ-018 SHALL register in_instr on accept.
  - If cond==1110 (AL), or cond==1111, or flag_wr_pend==0 on that same edge: evaluate with that cycle's cpsr and enter FULL.
  - Otherwise: enter WAIT.
REQ-019 SHALL remain in WAIT while flag_wr_pend==1; on the first edge with flag_wr_pend==0, evaluate using that cycle's cpsr and enter FULL.
REQ-020 SHALL handle FULL as follows:
  - out_ready==0: hold all outputs stable.
  - out_ready==1 and in_valid==1: accept back-to-back under REQ-018 rules.
  - out_ready==1 and in_valid==0: enter EMPTY.
REQ-021 SHALL give latency accept-to-out_valid of 1 cycle when not stalled, and 1+N cycles for N WAIT cycles.
REQ-022 SHALL sustain throughput of one instruction per cycle when out_ready==1 and flag_wr_pend==0.
REQ-023 SHALL evaluate out_exec as follows:
  - 0000 EQ: Z; 0001 NE: !Z; 0010 CS: C; 0011 CC: !C.
  - 0100 MI: N; 0101 PL: !N; 0110 VS: V; 0111 VC: !V.
  - 1000 HI: C&!Z; 1001 LS: !C|Z.
  - 1010 GE: N==V; 1011 LT: N!=V; 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: out_exec=0, out_undef=1.
REQ-024 SHALL set out_undef=0 for every condition other than 1111.
REQ-025 SHALL capture flags only at the evaluating edge; later cpsr changes while in FULL SHALL NOT alter out_exec.
REQ-026 SHALL increment stall_cnt by 1 on each edge spent in WAIT, saturate at 16'hFFFF, and clear it only by rst.
REQ-027 SHALL NOT mask in_ready by flag_wr_pend while in EMPTY; accept proceeds, then the block stalls in WAIT.

Reset
REQ-028 SHALL, on rst==1 at an edge, set:
  - state=EMPTY, out_valid=0, out_instr=32'h0, out_exec=0, out_undef=0, stall_cnt=16'h0.
REQ-029 SHALL give rst priority over accept, evaluation and hold.
REQ-030 SHALL, on rst in WAIT or FULL, discard the held instruction with no output produced.
REQ-031 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-032 SHALL cover: cpsr=32'h2000_0000 (Z=1), flag_wr_pend=0, in_instr=32'h0A00_0010 (EQ), out_ready=1 -> next cycle out_valid=1, out_exec=1, out_instr=32'h0A00_0010.
REQ-033 SHALL cover: cpsr=32'h9000_0000 (V=1,N=1), GT 32'hCA00_0000 then LT 32'hBA00_0000 back-to-back -> out_exec=1 then 0, one per cycle.
REQ-034 SHALL cover: accept NE with flag_wr_pend=1 for 3 cycles, cpsr changed to Z=0 on the release cycle -> out_valid after 4 cycles, out_exec=1, stall_cnt=3.
REQ-035 SHALL cover: FULL with out_ready=0 for 5 cycles and cpsr toggling -> outputs constant, in_ready=0.
REQ-036 SHALL cover: in_instr=32'hF000_0000 -> out_exec=0, out_undef=1; AL with flag_wr_pend=1 -> no WAIT, stall_cnt unchanged.
REQ-037 SHALL cover: rst asserted in WAIT -> next cycle out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/cond_eval.sv
// Condition-code evaluator: holds one instruction, waits out stale flags,
// then presents the instruction with its pass/undefined verdict.
module cond_eval (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpsr,
  input  logic        flag_wr_pend,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_exec,
  output logic        out_undef,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic        exec_q;
  logic        undef_q;
  logic [15:0] stall_q;

  logic        accept;
  logic        bypass;
  logic        eval_now;
  logic [3:0]  eval_cond;
  logic [3:0]  in_cond;
  logic        unused_cpsr;

  assign unused_cpsr = ^cpsr[27:0];

  // flags arrive as cpsr[31:28] = {V, C, Z, N}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] vczn);
    logic v, c, z, n;
    logic pass;
    v = vczn[3];
    c = vczn[2];
    z = vczn[1];
    n = vczn[0];
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c & !z;
      4'h9:    pass = !c | z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z & (n == v);
      4'hD:    pass = z | (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  assign in_cond = in_instr[31:28];
  assign accept  = in_valid & in_ready;
  // AL and NV ignore the flags, so they never need to wait for them
  assign bypass  = (in_cond == 4'hE) || (in_cond == 4'hF) || !flag_wr_pend;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = bypass ? ST_FULL : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!flag_wr_pend) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (accept) begin
            state_d = bypass ? ST_FULL : ST_WAIT;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_WAIT:  in_ready = 1'b0;
      ST_FULL: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Evaluate either the incoming word or the one parked in WAIT
  assign eval_now  = (accept && bypass) || ((state_q == ST_WAIT) && !flag_wr_pend);
  assign eval_cond = accept ? in_cond : instr_q[31:28];

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= 32'h0;
      exec_q  <= 1'b0;
      undef_q <= 1'b0;
      stall_q <= 16'h0;
    end else begin
      if (accept) begin
        instr_q <= in_instr;
      end
      if (eval_now) begin
        exec_q  <= cond_pass(eval_cond, cpsr[31:28]);
        undef_q <= (eval_cond == 4'hF);
      end
      if ((state_q == ST_WAIT) && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'h1;
      end
    end
  end

  assign out_instr = instr_q;
  assign out_exec  = exec_q;
  assign out_undef = undef_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cond_eval.sv
// Bench for cond_eval: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model.
module tb_cond_eval;

  logic        clk;
  logic        rst;
  logic [31:0] cpsr;
  logic        flag_wr_pend;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_exec;
  logic        out_undef;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: one slot, "have" = slot occupied, "evald" = verdict known
  bit        m_have  = 0;
  bit        m_evald = 0;
  bit [31:0] m_instr = 0;
  bit        m_exec  = 0;
  bit        m_undef = 0;
  int        m_stall = 0;
  bit        chk_en  = 0;

  cond_eval dut (
    .clk         (clk),
    .rst         (rst),
    .cpsr        (cpsr),
    .flag_wr_pend(flag_wr_pend),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_exec    (out_exec),
    .out_undef   (out_undef),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Conditions come in pairs: odd code is the inverse of the even one below it
  function automatic bit ref_exec(input bit [3:0] cond, input bit [31:0] flags);
    bit v, c, z, n, base;
    v = flags[31];
    c = flags[30];
    z = flags[29];
    n = flags[28];
    case (cond >> 1)
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (cond == 4'hE);
    endcase
    return base ^ cond[0];
  endfunction

  function automatic bit exp_ready();
    return !m_have || (m_evald && out_ready);
  endfunction

  task automatic model_eval(input bit [31:0] ins);
    m_exec  = ref_exec(ins[31:28], cpsr);
    m_undef = (ins[31:28] == 4'hF);
    m_evald = 1;
  endtask

  task automatic model_load();
    m_have  = 1;
    m_instr = in_instr;
    if (in_instr[31:28] == 4'hE || in_instr[31:28] == 4'hF || !flag_wr_pend) model_eval(in_instr);
    else m_evald = 0;
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_have = 0; m_evald = 0; m_instr = 0; m_exec = 0; m_undef = 0; m_stall = 0;
      chk_en = 1;
    end else begin
      acc = in_valid && exp_ready();
      if (m_have && !m_evald) begin
        if (m_stall < 65535) m_stall++;
        if (!flag_wr_pend) model_eval(m_instr);
      end else if (m_have) begin
        if (out_ready) begin
          if (acc) model_load();
          else m_have = 0;
        end
      end else if (acc) begin
        model_load();
      end
    end
  endtask

  task automatic model_checks();
    if (chk_en) begin
      check_eq("out_valid", out_valid, m_have && m_evald);
      check_eq("in_ready", in_ready, exp_ready());
      check_eq("stall_cnt", stall_cnt, m_stall);
      if (m_have && m_evald) begin
        check_eq("out_instr", out_instr, m_instr);
        check_eq("out_exec", out_exec, m_exec);
        check_eq("out_undef", out_undef, m_undef);
      end
    end
  endtask

  // One clock: drive, check pre-edge view against model, advance both
  task automatic cyc(input bit r, input bit v, input bit [31:0] ins, input bit p,
                     input bit [31:0] flags, input bit ordy);
    rst = r; in_valid = v; in_instr = ins; flag_wr_pend = p; cpsr = flags; out_ready = ordy;
    @(negedge clk);
    model_checks();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int s0;
    rst = 1; in_valid = 0; in_instr = 0; flag_wr_pend = 0; cpsr = 0; out_ready = 0;
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_exec", out_exec, 0);
    check_eq("rst_undef", out_undef, 0);
    check_eq("rst_stall", stall_cnt, 16'h0);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("post_rst_ready", in_ready, 1);

    // EQ with Z=1, single-cycle latency
    cyc(0, 1, 32'h0A00_0010, 0, 32'h2000_0000, 1);
    check_eq("eq_valid", out_valid, 1);
    check_eq("eq_exec", out_exec, 1);
    check_eq("eq_instr", out_instr, 32'h0A00_0010);

    // GT then LT back-to-back with N=V=1
    cyc(0, 1, 32'hCA00_0000, 0, 32'h9000_0000, 1);
    check_eq("gt_valid", out_valid, 1);
    check_eq("gt_exec", out_exec, 1);
    cyc(0, 1, 32'hBA00_0000, 0, 32'h9000_0000, 1);
    check_eq("lt_valid", out_valid, 1);
    check_eq("lt_exec", out_exec, 0);
    check_eq("lt_instr", out_instr, 32'hBA00_0000);
    cyc(0, 0, 0, 0, 0, 1);

    // NE stalled by pending flags for three cycles, Z cleared on release
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h1A00_0000, 1, 32'h2000_0000, 1);
    check_eq("ne_wait_ready", in_ready, 0);
    cyc(0, 0, 0, 1, 32'h2000_0000, 1);
    cyc(0, 0, 0, 1, 32'h2000_0000, 1);
    check_eq("ne_wait_valid", out_valid, 0);
    cyc(0, 0, 0, 0, 32'h0000_0000, 1);
    check_eq("ne_valid", out_valid, 1);
    check_eq("ne_exec", out_exec, 1);
    check_eq("ne_stall", stall_cnt, 16'd3);
    cyc(0, 0, 0, 0, 0, 1);

    // Hold in FULL with cpsr toggling underneath
    cyc(0, 1, 32'h0123_4567, 0, 32'h2000_0000, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, $urandom, i[0], (i % 2 == 0) ? 32'h0 : 32'hF000_0000, 0);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_exec", out_exec, 1);
      check_eq("hold_instr", out_instr, 32'h0123_4567);
      check_eq("hold_ready", in_ready, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);

    // NV, then AL with pending flags must not stall
    cyc(0, 1, 32'hF000_0000, 0, 32'hF000_0000, 1);
    check_eq("nv_exec", out_exec, 0);
    check_eq("nv_undef", out_undef, 1);
    s0 = m_stall;
    cyc(0, 1, 32'hE000_0000, 1, 32'h0, 1);
    check_eq("al_valid", out_valid, 1);
    check_eq("al_exec", out_exec, 1);
    check_eq("al_undef", out_undef, 0);
    check_eq("al_stall", stall_cnt, s0);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset while parked in WAIT
    cyc(0, 1, 32'h0A00_0000, 1, 32'h0, 1);
    cyc(0, 0, 0, 1, 32'h0, 1);
    cyc(1, 0, 0, 1, 32'h0, 1);
    check_eq("wrst_valid", out_valid, 0);
    check_eq("wrst_stall", stall_cnt, 16'h0);
    check_eq("wrst_ready", in_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
